// File: rtl/accumulator_reg_if.sv
// ---------------------------------------------------------------------------
// accumulator_reg_if
//
// Purpose:
//   Bundles the datapath-facing signals of the CPU accumulator register.
//   The ALU/bus result path drives the load request. The ALU operand A
//   path reads the register contents back.
//
// Signals:
//   acc_enable  1      load enable, sampled on the register's rising clk edge
//   data_in     WIDTH  word to load
//   data_out    WIDTH  current register contents (registered)
//
// Modports:
//   master  the datapath side: drives acc_enable/data_in, reads data_out
//   slave   the register itself: reads acc_enable/data_in, drives data_out
// ---------------------------------------------------------------------------
interface accumulator_reg_if #(
  parameter int WIDTH = 16
);

  logic             acc_enable;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output acc_enable,
    output data_in,
    input  data_out
  );

  modport slave (
    input  acc_enable,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/accumulator_reg.sv
// ---------------------------------------------------------------------------
// accumulator_reg
//
// Purpose:
//   CPU accumulator register. Holds one data word that the datapath reads
//   continuously. On a rising clk edge with acc_enable high, the register
//   captures data_in verbatim. Otherwise it holds its value. It never
//   modifies the word; any arithmetic happens upstream in the ALU.
//
// Parameters:
//   WIDTH        data word width in bits (CPU build uses 16)
//   RESET_VALUE  value forced onto the register while reset is asserted
//
// Ports:
//   clk    input   single clock; all state updates on the rising edge
//   reset  input   asynchronous, active-low reset (0 = reset asserted)
//   bus    slave   accumulator_reg_if carrying acc_enable, data_in, data_out
// ---------------------------------------------------------------------------
module accumulator_reg #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  accumulator_reg_if.slave  bus
);

  logic [WIDTH-1:0] acc_q;

  // Reset is in the sensitivity list, so asserting it clears the register
  // right away, with no clock edge needed. When reset falls in the same
  // time step as an enabled clock edge, the reset branch is evaluated last
  // or takes priority. Either way, the in-flight load is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= RESET_VALUE;
    end else if (bus.acc_enable) begin
      acc_q <= bus.data_in;
    end
  end

  // The output comes straight from the flop, so data_in has no
  // combinational path to operand A.
  assign bus.data_out = acc_q;

endmodule

// File: tb/tb_accumulator_reg.sv
// ---------------------------------------------------------------------------
// tb_accumulator_reg
//
// Purpose:
//   Self-checking bench for accumulator_reg. The stimulus process drives the
//   load interface once per cycle. For each cycle it pushes the value the
//   register should hold at the following falling edge. A separate monitor
//   pops that value on every falling edge and compares it. Asynchronous
//   reset behaviour is checked directly at the instant it must take effect.
// ---------------------------------------------------------------------------
module tb_accumulator_reg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_VAL = '0;

  logic clk;
  logic reset;

  accumulator_reg_if #(.WIDTH(WIDTH)) acc_bus ();

  accumulator_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (acc_bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // model_q is what the register holds now.
  // pending_q is what it will hold after the next rising edge.
  logic [WIDTH-1:0] model_q   = '0;
  logic [WIDTH-1:0] pending_q = '0;
  logic [WIDTH-1:0] exp_q[$];

  // The clock has a 10-unit period, with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // This task compares the current register output against a value the
  // bench computed itself.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expected);
    checks++;
    if (acc_bus.data_out !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at t=%0t",
               name, acc_bus.data_out, expected, $time);
    end
  endtask

  // This task runs one clock cycle of the load interface. After the rising
  // edge it records what the register must now hold. It then presents the
  // new request and predicts the next contents from the load/hold rule.
  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] data);
    @(posedge clk);
    model_q = reset ? pending_q : RESET_VAL;
    #2;
    exp_q.push_back(model_q);
    acc_bus.acc_enable = en;
    acc_bus.data_in    = data;
    pending_q = en ? data : model_q;
  endtask

  // This task pulses reset low between clock edges and checks that the
  // register clears immediately. The enable is dropped before release,
  // so the register is still at reset value when it next loads.
  task automatic pulseReset(input string name);
    @(negedge clk);
    #1 reset = 1'b0;
    model_q   = RESET_VAL;
    pending_q = RESET_VAL;
    #1 checkOutput(name, RESET_VAL);
    acc_bus.acc_enable = 1'b0;
    #1 reset = 1'b1;
  endtask

  // The monitor pops one expected word on every falling edge where the
  // stimulus side has produced one.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        checkOutput("scoreboard", exp_q.pop_front());
      end
    end
  end

  // The main stimulus sequence runs directed cases first, then random traffic.
  initial begin
    reset              = 1'b0;
    acc_bus.acc_enable = 1'b0;
    acc_bus.data_in    = '0;

    // The register must read RESET_VAL at power-up, before any clock edge.
    #1 checkOutput("power_up", RESET_VAL);

    // Reset holds the register even with an enabled load and toggling clock.
    acc_bus.acc_enable = 1'b1;
    acc_bus.data_in    = 16'hFFFF;
    @(posedge clk); #1 checkOutput("reset_hold_1", RESET_VAL);
    @(posedge clk); #1 checkOutput("reset_hold_2", RESET_VAL);
    acc_bus.acc_enable = 1'b0;
    @(negedge clk); #1 reset = 1'b1;

    // Basic loads are followed by a hold while data_in changes.
    applyStimulus(1'b1, 16'hAAAA);
    applyStimulus(1'b1, 16'hF0F0);
    applyStimulus(1'b0, 16'h5555);
    applyStimulus(1'b0, 16'h5555);
    applyStimulus(1'b0, 16'h5555);
    applyStimulus(1'b0, 16'h5555);

    // A load of 0x1234 is followed by an asynchronous reset pulse between
    // edges. The register stays clear afterwards while the enable is low.
    applyStimulus(1'b1, 16'h1234);
    applyStimulus(1'b0, 16'h0000);
    pulseReset("async_reset");
    applyStimulus(1'b0, 16'h5555);
    applyStimulus(1'b0, 16'h5555);

    // Latency case: data_in moves from 0x0001 to 0xFFFF mid-cycle. The
    // output keeps 0x0001 until the next enabled edge, then shows 0xFFFF.
    applyStimulus(1'b1, 16'h0001);
    applyStimulus(1'b1, 16'h0001);
    #4;
    acc_bus.data_in = 16'hFFFF;
    pending_q = 16'hFFFF;
    #1 checkOutput("latency_mid_cycle", 16'h0001);
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000);

    // Reset falls on the very edge that would load 0xBEEF. Reset must win.
    applyStimulus(1'b1, 16'hABCD);
    applyStimulus(1'b1, 16'hBEEF);
    @(posedge clk);
    reset = 1'b0;
    model_q   = RESET_VAL;
    pending_q = RESET_VAL;
    #1 checkOutput("reset_vs_load", RESET_VAL);
    @(posedge clk); #1 checkOutput("reset_vs_load_hold", RESET_VAL);
    acc_bus.acc_enable = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
    applyStimulus(1'b0, 16'h0000);

    // Random loads and holds, with occasional asynchronous reset pulses.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        pulseReset("rand_reset");
      end
    end
    applyStimulus(1'b0, 16'h0000);

    // Allow the monitor to drain the last expected words, within a bounded wait.
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d expected words left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
